// File: rtl/mdu_hilo_if.sv
// Issue/result bundle between the E stage and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
  logic        start;
  logic [3:0]  hilo_type;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, hilo_type, rs_data, rt_data,
    input  busy, hilo_rd, hi, lo
  );

  modport slave (
    input  start, hilo_type, rs_data, rt_data,
    output busy, hilo_rd, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle mult/multu/div/divu unit owning the HI/LO registers.
// Define MDU_DIVIDE_EN to build div/divu; without it codes 1 and 3 behave as none.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_hilo_if.slave mdu
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
`ifdef MDU_DIVIDE_EN
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd3;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [3:0]       op_q;
  logic [31:0]      op_a_q;
  logic [31:0]      op_b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic             md_start_s;
  logic [CNT_W-1:0] cnt_init_s;
  logic             mul_sgn_s;
  logic [63:0]      prod_s;
  logic [31:0]      res_hi_s;
  logic [31:0]      res_lo_s;
  logic             res_wr_s;

  // Decode which codes launch a multi-cycle op and how long it runs.
  always_comb begin
    md_start_s = 1'b0;
    cnt_init_s = CNT_W'(MULT_CYCLES);
    case (mdu.hilo_type)
      OP_MULT, OP_MULTU: begin
        md_start_s = 1'b1;
        cnt_init_s = CNT_W'(MULT_CYCLES);
      end
`ifdef MDU_DIVIDE_EN
      OP_DIV, OP_DIVU: begin
        md_start_s = 1'b1;
        cnt_init_s = CNT_W'(DIV_CYCLES);
      end
`endif
      default: begin
        md_start_s = 1'b0;
        cnt_init_s = CNT_W'(MULT_CYCLES);
      end
    endcase
  end

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  always_comb begin
    mul_sgn_s = (op_q == OP_MULT);
    prod_s    = {{32{mul_sgn_s & op_a_q[31]}}, op_a_q} *
                {{32{mul_sgn_s & op_b_q[31]}}, op_b_q};
  end

`ifdef MDU_DIVIDE_EN
  logic        div_sgn_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] uquo_s;
  logic [31:0] urem_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Signed divide as magnitude divide plus sign fix-up; 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    div_sgn_s = (op_q == OP_DIV);
    neg_a_s   = div_sgn_s & op_a_q[31];
    neg_b_s   = div_sgn_s & op_b_q[31];
    abs_a_s   = neg_a_s ? (32'd0 - op_a_q) : op_a_q;
    abs_b_s   = neg_b_s ? (32'd0 - op_b_q) : op_b_q;
    if (abs_b_s != 32'd0) begin
      uquo_s = abs_a_s / abs_b_s;
      urem_s = abs_a_s % abs_b_s;
    end else begin
      uquo_s = 32'd0;
      urem_s = 32'd0;
    end
    quo_s = (neg_a_s ^ neg_b_s) ? (32'd0 - uquo_s) : uquo_s;
    rem_s = neg_a_s ? (32'd0 - urem_s) : urem_s;
  end
`endif

  // Select the result written on the final busy edge; a zero divisor writes nothing.
  always_comb begin
    res_hi_s = hi_q;
    res_lo_s = lo_q;
    res_wr_s = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        res_wr_s = 1'b1;
      end
`ifdef MDU_DIVIDE_EN
      OP_DIV, OP_DIVU: begin
        res_hi_s = rem_s;
        res_lo_s = quo_s;
        if (op_b_q != 32'd0) begin
          res_wr_s = 1'b1;
        end else begin
          res_wr_s = 1'b0;
        end
      end
`endif
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
        res_wr_s = 1'b0;
      end
    endcase
  end

  // Control FSM with operand latch, busy counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mdu.start && md_start_s) begin
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
            cnt_q   <= cnt_init_s;
            op_q    <= mdu.hilo_type;
            op_a_q  <= mdu.rs_data;
            op_b_q  <= mdu.rt_data;
          end else if (mdu.start && (mdu.hilo_type == OP_MTHI)) begin
            hi_q <= mdu.rs_data;
          end else if (mdu.start && (mdu.hilo_type == OP_MTLO)) begin
            lo_q <= mdu.rs_data;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          // Any start while busy is deliberately dropped here.
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (res_wr_s) begin
              hi_q <= res_hi_s;
              lo_q <= res_lo_s;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // mfhi/mflo read port straight off the registers.
  always_comb begin
    case (mdu.hilo_type)
      OP_MFHI: mdu.hilo_rd = hi_q;
      OP_MFLO: mdu.hilo_rd = lo_q;
      default: mdu.hilo_rd = 32'd0;
    endcase
  end

  assign mdu.busy = busy_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed test-plan cases, then random traffic vs a reference model.
module tb_mdu_hilo;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mdu_hilo_if bus ();

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: architectural HI/LO, busy cycles left, pending result.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          m_left;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; p_wr = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [31:0] a, b;
    logic [63:0] u;
    longint      s;
    int          sa, sb;
    a = bus.rs_data;
    b = bus.rt_data;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.start) begin
      case (bus.hilo_type)
        4'd0: begin
          s = longint'($signed(a)) * longint'($signed(b));
          {p_hi, p_lo} = s; p_wr = 1'b1; m_left = MC;
        end
        4'd2: begin
          u = {32'd0, a} * {32'd0, b};
          {p_hi, p_lo} = u; p_wr = 1'b1; m_left = MC;
        end
`ifdef MDU_DIVIDE_EN
        4'd1: begin
          sa = a; sb = b; m_left = DC; p_wr = (b != 32'd0);
          if (sb == 0) begin
            p_hi = 32'd0; p_lo = 32'd0;
          end else if (a == 32'h8000_0000 && sb == -1) begin
            p_lo = 32'h8000_0000; p_hi = 32'd0;
          end else begin
            p_lo = sa / sb; p_hi = sa % sb;
          end
        end
        4'd3: begin
          m_left = DC; p_wr = (b != 32'd0);
          p_lo = (b != 32'd0) ? a / b : 32'd0;
          p_hi = (b != 32'd0) ? a % b : 32'd0;
        end
`endif
        4'd6: m_hi = a;
        4'd7: m_lo = a;
        default: ;
      endcase
    end
  endfunction

  task automatic check_model();
    logic [31:0] exp_rd;
    exp_rd = (bus.hilo_type == 4'd4) ? m_hi : (bus.hilo_type == 4'd5) ? m_lo : 32'd0;
    check_eq("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
    check_eq("hi", bus.hi, m_hi);
    check_eq("lo", bus.lo, m_lo);
    check_eq("hilo_rd", bus.hilo_rd, exp_rd);
  endtask

  // One clock: predict the edge, let it happen, compare shortly after.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.hilo_type = code; bus.rs_data = a; bus.rt_data = b;
    cyc();
    bus.start = 1'b0; bus.hilo_type = 4'd8;
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_hi", bus.hi, 32'd0);
    check_eq("rst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return $urandom % 32'd16;
      default: return $urandom;
    endcase
  endfunction

  int bcount;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.hilo_type = 4'd8; bus.rs_data = 32'd0; bus.rt_data = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    #3;
    reset = 1'b1;
    cyc();

    // mult -1 * 2
    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    bcount = bus.busy;
    for (int i = 0; i < MC + 1; i++) begin cyc(); bcount += bus.busy; end
    check_eq("mult_busy_len", bcount, MC);
    check_eq("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", bus.lo, 32'hFFFF_FFFE);

    // multu with operands disturbed while busy
    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    for (int i = 0; i < MC; i++) begin
      bus.rs_data = $urandom; bus.rt_data = $urandom;
      cyc();
    end
    check_eq("multu_hi", bus.hi, 32'h0000_0001);
    check_eq("multu_lo", bus.lo, 32'hFFFF_FFFE);

    // mthi then mflo/mfhi reads
    issue(4'd6, 32'h0000_1234, 32'd0);
    bus.start = 1'b1; bus.hilo_type = 4'd5; cyc();
    bus.hilo_type = 4'd4; #1;
    check_eq("mfhi_rd", bus.hilo_rd, 32'h0000_1234);
    cyc();
    bus.start = 1'b0;

    // back-to-back issue on the busy-drop cycle
    issue(4'd0, 32'd3, 32'd7);
    repeat (MC) cyc();
    check_eq("drop_busy", {31'd0, bus.busy}, 32'd0);
    issue(4'd2, 32'd6, 32'd9);
    check_eq("b2b_busy", {31'd0, bus.busy}, 32'd1);
    repeat (MC) cyc();
    check_eq("b2b_lo", bus.lo, 32'd54);

    // mtlo pulsed mid-mult is ignored
    issue(4'd0, 32'd3, 32'd5);
    cyc();
    bus.start = 1'b1; bus.hilo_type = 4'd7; bus.rs_data = 32'h0000_DEAD;
    cyc();
    bus.start = 1'b0; bus.hilo_type = 4'd8;
    repeat (MC) cyc();
    check_eq("ignore_mtlo_lo", bus.lo, 32'd15);

`ifdef MDU_DIVIDE_EN
    issue(4'd1, 32'hFFFF_FFF9, 32'd2);
    bcount = bus.busy;
    for (int i = 0; i < DC + 1; i++) begin cyc(); bcount += bus.busy; end
    check_eq("div_busy_len", bcount, DC);
    check_eq("div_lo", bus.lo, 32'hFFFF_FFFD);
    check_eq("div_hi", bus.hi, 32'hFFFF_FFFF);
    issue(4'd6, 32'h55, 32'd0);
    issue(4'd7, 32'h55, 32'd0);
    issue(4'd3, 32'd7, 32'd0);
    bcount = bus.busy;
    for (int i = 0; i < DC + 1; i++) begin cyc(); bcount += bus.busy; end
    check_eq("div0_busy_len", bcount, DC);
    check_eq("div0_hi", bus.hi, 32'h55);
    check_eq("div0_lo", bus.lo, 32'h55);
    issue(4'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DC) cyc();
    check_eq("ovf_lo", bus.lo, 32'h8000_0000);
    check_eq("ovf_hi", bus.hi, 32'd0);
    issue(4'd1, 32'd100, 32'd7);
`else
    issue(4'd6, 32'h77, 32'd0);
    issue(4'd1, 32'd10, 32'd3);
    check_eq("nodiv_busy", {31'd0, bus.busy}, 32'd0);
    issue(4'd3, 32'd10, 32'd3);
    check_eq("nodivu_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("nodiv_hi", bus.hi, 32'h77);
    issue(4'd0, 32'd100, 32'd7);
`endif
    // async reset on busy cycle 3
    cyc(); cyc();
    async_reset();
    repeat (DC + 2) cyc();
    check_eq("post_rst_lo", bus.lo, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.start     = ($urandom % 3) != 0;
      bus.hilo_type = (($urandom % 5) != 0) ? 4'($urandom % 8) : 4'($urandom_range(8, 15));
      bus.rs_data   = rnd_op();
      bus.rt_data   = rnd_op();
      if (($urandom % 400) == 0) async_reset();
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
